// File: rtl/spi_acl_pkg.sv
// Shared constants and types for the ADXL362-style SPI responder.
// Also imported by the matching SPI master.
package spi_acl_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h0A;
  localparam logic [7:0] CMD_READ   = 8'h0B;

  localparam logic [7:0] DEVID_AD   = 8'h00;
  localparam logic [7:0] XDATA_L    = 8'h0E;
  localparam logic [7:0] XDATA_H    = 8'h0F;
  localparam logic [7:0] YDATA_L    = 8'h10;
  localparam logic [7:0] YDATA_H    = 8'h11;
  localparam logic [7:0] ZDATA_L    = 8'h12;
  localparam logic [7:0] ZDATA_H    = 8'h13;
  localparam logic [7:0] POWER_CTL  = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } spi_state_t;

  function automatic logic is_ro(input logic [7:0] a);
    return (a == DEVID_AD) || ((a >= XDATA_L) && (a <= ZDATA_H));
  endfunction

endpackage

// File: rtl/spi_acl_responder_if.sv
// SPI bus bundle between accelerometer master and responder.
// miso is 0 whenever the responder is not selected.
interface spi_acl_responder_if;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic miso;

  modport master (output sclk, output mosi, output cs_n, input miso);
  modport slave  (input sclk, input mosi, input cs_n, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one async SPI pin plus
// single-flop rise/fall detection on the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer and keep the last level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_acl_responder.sv
// ADXL362-style SPI responder: register file, sample snapshot, burst access.
// Optional data-ready interrupt enabled by macro SPI_RESP_INT_EN.
module spi_acl_responder
  import spi_acl_pkg::*;
#(
  parameter int         ADDR_W      = 6,
  parameter logic [7:0] DEVID       = 8'hAD,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_acl_responder_if.slave spi,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  input  logic signed [15:0] z_in,
  input  logic               sample_valid,
  output logic               wr_strobe,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [7:0]         wr_data,
  output logic               busy,
  output logic               int_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic sclk_rise, sclk_fall;
  logic mosi_s;
  logic cs_s, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(spi.sclk),
    .level(), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(spi.mosi),
    .level(mosi_s), .rise(), .fall()
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(spi.cs_n),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_state_t        state_q, state_d;
  logic [7:0]        regs [DEPTH];
  logic [47:0]       live_q, snap_q;
  logic [6:0]        sh_in;
  logic [2:0]        bit_cnt, fall_cnt;
  logic [7:0]        sh_out;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q, miso_q, cover_q;

  logic [7:0]        rx_byte;
  logic              byte_done;
  logic [ADDR_W-1:0] addr_nx, addr_rx;
  logic              wr_commit;

  assign rx_byte   = {sh_in, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign addr_nx   = addr_q + ADDR_W'(1);
  assign addr_rx   = rx_byte[ADDR_W-1:0];
  assign wr_commit = (state_q == ST_WDATA) && byte_done
                   && !is_ro(8'(addr_q));

  function automatic logic [7:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [7:0] a8;
    logic [7:0] off;
    a8  = 8'(a);
    off = a8 - XDATA_L;
    if ((a8 >= XDATA_L) && (a8 <= ZDATA_H))
      return snap_q[{off[2:0], 3'b000} +: 8];
    return regs[a];
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: byte boundaries advance, cs_n rise always ends
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD:
        if (byte_done)
          state_d = ((rx_byte == CMD_WRITE) || (rx_byte == CMD_READ))
                  ? ST_ADDR : ST_IGNORE;
      ST_ADDR:
        if (byte_done) state_d = rd_q ? ST_RDATA : ST_WDATA;
      default: ;
    endcase
    if (cs_rise) state_d = ST_IDLE;
  end

  // Live sample capture; snapshot freezes it at transaction start
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      snap_q <= '0;
    end else begin
      if (sample_valid) live_q <= {z_in, y_in, x_in};
      if (cs_fall)      snap_q <= live_q;
    end
  end

  // Register file and write-report outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= (i == 0) ? DEVID : 8'h00;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (wr_commit) begin
        regs[addr_q] <= rx_byte;
        wr_strobe    <= 1'b1;
        wr_addr      <= addr_q;
        wr_data      <= rx_byte;
      end
    end
  end

  // Serial shift, address tracking and miso drive
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_in    <= '0;
      bit_cnt  <= '0;
      fall_cnt <= '0;
      sh_out   <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      miso_q   <= 1'b0;
      cover_q  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (cs_fall) begin
        bit_cnt  <= '0;
        fall_cnt <= '0;
        cover_q  <= 1'b0;
        busy     <= 1'b1;
      end
      if (sclk_rise && (state_q != ST_IDLE)) begin
        sh_in   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if ((state_q == ST_CMD) && byte_done)
        rd_q <= (rx_byte == CMD_READ);
      if ((state_q == ST_ADDR) && byte_done) begin
        addr_q <= addr_rx;
        if (rd_q) begin
          sh_out   <= rd_val(addr_rx);
          fall_cnt <= '0;
          cover_q  <= (8'(addr_rx) == XDATA_L);
        end
      end
      if ((state_q == ST_WDATA) && byte_done)
        addr_q <= addr_nx;
      if ((state_q == ST_RDATA) && sclk_fall) begin
        miso_q   <= sh_out[7];
        fall_cnt <= fall_cnt + 3'd1;
        if (fall_cnt == 3'd7) begin
          sh_out <= rd_val(addr_nx);
          addr_q <= addr_nx;
          if (8'(addr_nx) == XDATA_L) cover_q <= 1'b1;
        end else begin
          sh_out <= {sh_out[6:0], 1'b0};
        end
      end
      if (cs_rise) begin
        miso_q <= 1'b0;
        busy   <= 1'b0;
      end
    end
  end

  assign spi.miso = miso_q & ~cs_s;

`ifdef SPI_RESP_INT_EN
  localparam logic [ADDR_W-1:0] PWR_IDX = ADDR_W'(POWER_CTL);

  logic int_q;
  logic int_set, int_clr;

  assign int_set = sample_valid && (regs[PWR_IDX][1:0] == 2'b10);
  assign int_clr = cs_rise && rd_q && cover_q
                 && (state_q == ST_RDATA);

  // Data-ready flag: set on new sample, cleared once X was read out
  always_ff @(posedge clk) begin
    if (rst)          int_q <= 1'b0;
    else if (int_set) int_q <= 1'b1;
    else if (int_clr) int_q <= 1'b0;
  end

  assign int_out = int_q;
`else
  assign int_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_acl_responder.sv
// Directed bench for spi_acl_responder driving SPI mode 0 at clk/16.
// Immediate assertions at each check point; one summary line at the end.
module tb_spi_acl_responder;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] x_in, y_in, z_in;
  logic               sample_valid;
  logic               wr_strobe;
  logic [5:0]         wr_addr;
  logic [7:0]         wr_data;
  logic               busy;
  logic               int_out;

  spi_acl_responder_if spi ();

  spi_acl_responder dut (
    .clk(clk), .rst(rst), .spi(spi),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .sample_valid(sample_valid),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .int_out(int_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic [7:0] rx, rbuf [8];
  int s0;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobes++;
      last_addr = {2'b00, wr_addr};
      last_data = wr_data;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi.mosi = tx[7-i];
      #80;
      r = {r[6:0], spi.miso};
      spi.sclk = 1'b1;
      #80;
      spi.sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_low;
    spi.cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high;
    #80;
    spi.cs_n = 1'b1;
    #200;
  endtask

  task automatic spi_read(input logic [7:0] a, input int n);
    logic [7:0] d;
    cs_low();
    spi_byte(8'h0B, d);
    spi_byte(a, d);
    for (int i = 0; i < n; i++) spi_byte(8'h00, rbuf[i]);
    cs_high();
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d0,
                           input logic [7:0] d1, input int n);
    logic [7:0] d;
    cs_low();
    spi_byte(8'h0A, d);
    spi_byte(a, d);
    spi_byte(d0, d);
    if (n > 1) spi_byte(d1, d);
    cs_high();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] z);
    @(negedge clk);
    x_in = x; y_in = y; z_in = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    spi.sclk = 1'b0; spi.mosi = 1'b0; spi.cs_n = 1'b1;
    x_in = '0; y_in = '0; z_in = '0; sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_miso", spi.miso, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_int", int_out, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // DEVID read, command/address phases must not drive miso
    cs_low();
    check("busy_on_cs", busy, 1);
    spi_byte(8'h0B, rx);
    check("cmd_miso", rx, 8'h00);
    spi_byte(8'h00, rx);
    check("addr_miso", rx, 8'h00);
    spi_byte(8'h00, rx);
    check("devid", rx, 8'hAD);
    cs_high();
    check("busy_after_cs", busy, 0);
    check("no_strobe_read", strobes, 0);

    // Single write and read-back
    spi_write(8'h2C, 8'h53, 8'h00, 1);
    check("wr_count", strobes, 1);
    check("wr_addr", last_addr, 8'h2C);
    check("wr_data", last_data, 8'h53);
    spi_read(8'h2C, 1);
    check("rd_2c", rbuf[0], 8'h53);

    // Coherent burst of the snapshot, samples changed mid-burst
    pulse_sample(16'h0123, 16'h0456, 16'h0789);
    cs_low();
    spi_byte(8'h0B, rx);
    spi_byte(8'h0E, rx);
    spi_byte(8'h00, rbuf[0]);
    spi_byte(8'h00, rbuf[1]);
    pulse_sample(16'hFEDC, 16'hBA98, 16'h7654);
    for (int i = 2; i < 6; i++) spi_byte(8'h00, rbuf[i]);
    cs_high();
    check("xl", rbuf[0], 8'h23);
    check("xh", rbuf[1], 8'h01);
    check("yl", rbuf[2], 8'h56);
    check("yh", rbuf[3], 8'h04);
    check("zl", rbuf[4], 8'h89);
    check("zh", rbuf[5], 8'h07);
    spi_read(8'h0E, 1);
    check("xl_new", rbuf[0], 8'hDC);

    // Burst write across the wrap into read-only 0x00
    s0 = strobes;
    spi_write(8'h3F, 8'h11, 8'h22, 2);
    check("wrap_count", strobes - s0, 1);
    check("wrap_addr", last_addr, 8'h3F);
    check("wrap_data", last_data, 8'h11);
    spi_read(8'h3F, 2);
    check("rd_3f", rbuf[0], 8'h11);
    check("rd_wrap_00", rbuf[1], 8'hAD);

    // Write to read-only snapshot address is dropped
    s0 = strobes;
    spi_write(8'h0F, 8'h5A, 8'h00, 1);
    check("ro_snap_count", strobes - s0, 0);

    // Unknown command is ignored entirely
    s0 = strobes;
    cs_low();
    spi_byte(8'h0D, rx);
    spi_byte(8'h2C, rx);
    check("ign_miso1", rx, 8'h00);
    spi_byte(8'h99, rx);
    check("ign_miso2", rx, 8'h00);
    cs_high();
    check("ign_count", strobes - s0, 0);
    check("ign_busy", busy, 0);

    // Aborted write after 5 data bits
    cs_low();
    spi_byte(8'h0A, rx);
    spi_byte(8'h2C, rx);
    spi_bits(8'h99, 5, rx);
    cs_high();
    check("abort_count", strobes - s0, 0);
    spi_read(8'h2C, 1);
    check("abort_rd_2c", rbuf[0], 8'h53);

    // Reset in the middle of a write data byte
    cs_low();
    spi_byte(8'h0A, rx);
    spi_byte(8'h2C, rx);
    spi_bits(8'h77, 6, rx);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_strobe", wr_strobe, 0);
    check("mid_rst_miso", spi.miso, 0);
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    spi_read(8'h2C, 1);
    check("rst_rd_2c", rbuf[0], 8'h00);
    check("rst_count", strobes - s0, 0);
    spi_read(8'h00, 1);
    check("rst_devid", rbuf[0], 8'hAD);

    // Data-ready interrupt
    spi_write(8'h2D, 8'h02, 8'h00, 1);
    pulse_sample(16'h0001, 16'h0002, 16'h0003);
    repeat (2) @(negedge clk);
`ifdef SPI_RESP_INT_EN
    check("int_set", int_out, 1);
`else
    check("int_tied", int_out, 0);
`endif
    spi_read(8'h0E, 6);
    check("int_clr", int_out, 0);
    check("int_xl", rbuf[0], 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
